// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write arbiter.
// The hold entry format and the arbiter side encoding live here.
package rf_pkg;

   localparam int RF_AW   = 3;
   localparam int RF_DW   = 8;
   localparam int RF_NREG = 1 << RF_AW;

   typedef struct packed {
      logic             v;
      logic [RF_AW-1:0] addr;
      logic [RF_DW-1:0] data;
   } rf_wr_t;

   typedef enum logic {
      SIDE_A = 1'b0,
      SIDE_B = 1'b1
   } rf_side_e;

   function automatic rf_side_e other_side(input rf_side_e s);
      return (s == SIDE_A) ? SIDE_B : SIDE_A;
   endfunction

endpackage

// File: rtl/rf_req_hold.sv
// One-entry write holding register: loads on valid&ready and drains when granted.
// Ready is high when empty or draining this cycle, so it refills back-to-back; held at 0 in reset.
module rf_req_hold
   import rf_pkg::*;
(
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             valid,
   output logic             ready,
   input  logic [RF_AW-1:0] addr,
   input  logic [RF_DW-1:0] data,
   input  logic             gnt,
   output rf_wr_t           hold
);

   assign ready = Rst_n & (~hold.v | gnt);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         hold <= '0;
      end else if (valid && ready) begin
         hold <= '{v: 1'b1, addr: addr, data: data};
      end else if (gnt) begin
         hold.v <= 1'b0;
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-requester arbiter for the register-file write port; accept->We is 1 cycle plus 1 per lost round.
// Round-robin by default; defining FIXED_PRIO_EN makes A always win. Losing side's ready stays low.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int AW   = RF_AW,
   parameter int DW   = RF_DW,
   parameter int NREG = 1 << AW
) (
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            A_valid,
   output logic            A_ready,
   input  logic [AW-1:0]   A_addr,
   input  logic [DW-1:0]   A_data,
   input  logic            B_valid,
   output logic            B_ready,
   input  logic [AW-1:0]   B_addr,
   input  logic [DW-1:0]   B_data,
   output logic            We,
   output logic [AW-1:0]   Waddr,
   output logic [DW-1:0]   Wdata,
   output logic [NREG-1:0] Pending,
   output logic            Idle
);

   rf_wr_t hold_a;
   rf_wr_t hold_b;
   logic   gnt_a;
   logic   gnt_b;

   rf_req_hold u_hold_a (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .valid (A_valid),
      .ready (A_ready),
      .addr  (A_addr),
      .data  (A_data),
      .gnt   (gnt_a),
      .hold  (hold_a)
   );

   rf_req_hold u_hold_b (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .valid (B_valid),
      .ready (B_ready),
      .addr  (B_addr),
      .data  (B_data),
      .gnt   (gnt_b),
      .hold  (hold_b)
   );

`ifdef FIXED_PRIO_EN
   assign gnt_a = hold_a.v;
   assign gnt_b = hold_b.v & ~hold_a.v;
`else
   rf_side_e rr_ptr;

   // Only the hold valids enter arbitration, so ready never depends on the inputs.
   assign gnt_a = hold_a.v & (~hold_b.v | (rr_ptr == SIDE_A));
   assign gnt_b = hold_b.v & (~hold_a.v | (rr_ptr == SIDE_B));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rr_ptr <= SIDE_A;
      end else if (gnt_a || gnt_b) begin
         rr_ptr <= other_side(gnt_a ? SIDE_A : SIDE_B);
      end
   end
`endif

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         We    <= 1'b0;
         Waddr <= '0;
         Wdata <= '0;
      end else begin
         We <= gnt_a | gnt_b;
         if (gnt_a) begin
            Waddr <= hold_a.addr;
            Wdata <= hold_a.data;
         end else if (gnt_b) begin
            Waddr <= hold_b.addr;
            Wdata <= hold_b.data;
         end
      end
   end

   always_comb begin
      Pending = '0;
      for (int i = 0; i < NREG; i++) begin
         Pending[i] = (hold_a.v & (hold_a.addr == AW'(i)))
                    | (hold_b.v & (hold_b.addr == AW'(i)))
                    | (We & (Waddr == AW'(i)));
      end
   end

   assign Idle = ~hold_a.v & ~hold_b.v & ~We;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with an in-order write scoreboard and a register-file model.
module tb_rf_write_arbiter;
   import rf_pkg::*;

   logic       Clk;
   logic       Rst_n;
   logic       A_valid, A_ready, B_valid, B_ready;
   logic [2:0] A_addr, B_addr, Waddr;
   logic [7:0] A_data, B_data, Wdata;
   logic       We, Idle;
   logic [7:0] Pending;

   int total = 0;
   int bad   = 0;
   int we_cnt = 0;
   int w0;
   int ia, ib;
   logic acc_a, acc_b;
   logic [10:0] exp_q[$];
   logic [7:0]  rf_m [8];

   rf_write_arbiter dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .A_valid (A_valid),
      .A_ready (A_ready),
      .A_addr  (A_addr),
      .A_data  (A_data),
      .B_valid (B_valid),
      .B_ready (B_ready),
      .B_addr  (B_addr),
      .B_data  (B_data),
      .We      (We),
      .Waddr   (Waddr),
      .Wdata   (Wdata),
      .Pending (Pending),
      .Idle    (Idle)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   // Register-file model and in-order scoreboard fed by the write port.
   always @(posedge Clk) begin
      if (Rst_n === 1'b1 && We === 1'b1) rf_m[Waddr] <= Wdata;
   end

   always @(negedge Clk) begin
      if (Rst_n === 1'b1 && We === 1'b1) begin
         logic [10:0] e;
         we_cnt++;
         if (exp_q.size() == 0) begin
            check("spurious_write", 32'(exp_q.size()), 1);
         end else begin
            e = exp_q.pop_front();
            check("waddr", 32'(Waddr), 32'(e[10:8]));
            check("wdata", 32'(Wdata), 32'(e[7:0]));
         end
      end
   end

   initial begin
      Rst_n = 1'b0;
      A_valid = 1'b0; A_addr = '0; A_data = '0;
      B_valid = 1'b0; B_addr = '0; B_data = '0;
      for (int i = 0; i < 8; i++) rf_m[i] = '0;

      // Power-on reset
      #12;
      check("rst_we", 32'(We), 0);
      check("rst_pending", 32'(Pending), 0);
      check("rst_idle", 32'(Idle), 1);
      check("rst_a_ready", 32'(A_ready), 0);
      check("rst_b_ready", 32'(B_ready), 0);
      @(negedge Clk);
      Rst_n = 1'b1;
      cyc();
      check("a_ready_after_rst", 32'(A_ready), 1);

      // Single write from A
      A_valid = 1'b1; A_addr = 3'd3; A_data = 8'h5A;
      exp_q.push_back({3'd3, 8'h5A});
      cyc();
      A_valid = 1'b0;
      check("sw_pending_held", 32'(Pending), 32'h08);
      check("sw_we_low", 32'(We), 0);
      check("sw_idle_low", 32'(Idle), 0);
      cyc();
      check("sw_we", 32'(We), 1);
      check("sw_waddr", 32'(Waddr), 3);
      check("sw_wdata", 32'(Wdata), 32'h5A);
      check("sw_pending_port", 32'(Pending), 32'h08);
      cyc();
      check("sw_we_drop", 32'(We), 0);
      check("sw_pending_clr", 32'(Pending), 0);
      check("sw_idle", 32'(Idle), 1);

      // Reset mid-stream with both holds full
      A_valid = 1'b1; A_addr = 3'd1; A_data = 8'h33;
      B_valid = 1'b1; B_addr = 3'd2; B_data = 8'h44;
      cyc();
      A_valid = 1'b0; B_valid = 1'b0;
      check("mr_pending_full", 32'(Pending), 32'h06);
      Rst_n = 1'b0;
      #1;
      check("mr_we", 32'(We), 0);
      check("mr_pending", 32'(Pending), 0);
      check("mr_idle", 32'(Idle), 1);
      check("mr_a_ready", 32'(A_ready), 0);
      check("mr_b_ready", 32'(B_ready), 0);
      @(negedge Clk);
      Rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("mr_no_write", 32'(We), 0);
      end

      // Round-robin contention starting from reset state
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({3'(i), 8'(8'hA0 + i)});
         exp_q.push_back({3'(4 + i), 8'(8'hB0 + i)});
      end
      ia = 0; ib = 0;
      for (int c = 0; c < 20 && !(ia == 4 && ib == 4); c++) begin
         A_valid = (ia < 4); A_addr = 3'(ia);     A_data = 8'(8'hA0 + ia);
         B_valid = (ib < 4); B_addr = 3'(4 + ib); B_data = 8'(8'hB0 + ib);
         if (c >= 1 && c <= 6) begin
            check("rr_a_ready", 32'(A_ready), 32'(c % 2 == 1));
            check("rr_b_ready", 32'(B_ready), 32'(c % 2 == 0));
         end
         acc_a = A_valid & A_ready;
         acc_b = B_valid & B_ready;
         cyc();
         ia += int'(acc_a);
         ib += int'(acc_b);
      end
      A_valid = 1'b0; B_valid = 1'b0;
      check("rr_a_count", 32'(ia), 4);
      check("rr_b_count", 32'(ib), 4);
      repeat (4) cyc();
      check("rr_drained", 32'(exp_q.size()), 0);

      // Same address from both sides, pointer back on A
      A_valid = 1'b1; A_addr = 3'd5; A_data = 8'h11;
      B_valid = 1'b1; B_addr = 3'd5; B_data = 8'h22;
      exp_q.push_back({3'd5, 8'h11});
      exp_q.push_back({3'd5, 8'h22});
      check("sa_a_ready", 32'(A_ready), 1);
      check("sa_b_ready", 32'(B_ready), 1);
      w0 = we_cnt;
      cyc();
      A_valid = 1'b0; B_valid = 1'b0;
      repeat (4) cyc();
      check("sa_we_pulses", 32'(we_cnt - w0), 2);
      check("sa_final_r5", 32'(rf_m[5]), 32'h22);
      check("sa_drained", 32'(exp_q.size()), 0);

      // B streams eight back-to-back writes
      w0 = we_cnt;
      for (int i = 0; i < 8; i++) begin
         B_valid = 1'b1; B_addr = 3'(i); B_data = 8'(8'h80 + i);
         exp_q.push_back({3'(i), 8'(8'h80 + i)});
         check("st_b_ready", 32'(B_ready), 1);
         cyc();
         if (i >= 1) check("st_we_high", 32'(We), 1);
      end
      B_valid = 1'b0;
      cyc();
      check("st_we_last", 32'(We), 1);
      cyc();
      check("st_we_drop", 32'(We), 0);
      check("st_we_count", 32'(we_cnt - w0), 8);
      for (int i = 0; i < 8; i++) check("st_rf", 32'(rf_m[i]), 32'(8'h80 + i));

`ifdef FIXED_PRIO_EN
      // A streams continuously; B's single write waits until A stops
      for (int i = 0; i < 5; i++) exp_q.push_back({3'(i), 8'(8'hC0 + i)});
      exp_q.push_back({3'd7, 8'hD7});
      ia = 0; ib = 0;
      for (int c = 0; c < 20 && !(ia == 5 && ib == 1); c++) begin
         A_valid = (ia < 5); A_addr = 3'(ia); A_data = 8'(8'hC0 + ia);
         B_valid = (ib < 1); B_addr = 3'd7;   B_data = 8'hD7;
         if (c >= 1 && ia < 5) check("fp_b_ready_low", 32'(B_ready), 0);
         acc_a = A_valid & A_ready;
         acc_b = B_valid & B_ready;
         cyc();
         ia += int'(acc_a);
         ib += int'(acc_b);
      end
      A_valid = 1'b0; B_valid = 1'b0;
      repeat (4) cyc();
      check("fp_drained", 32'(exp_q.size()), 0);
      check("fp_r7", 32'(rf_m[7]), 32'hD7);
`endif

      check("end_idle", 32'(Idle), 1);
      check("end_queue", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port of the 8x8 register file between two requesters.
  - Requester A: pipeline writeback.
  - Requester B: host/debug load port.
- Each side has a one-entry holding register with a valid/ready handshake.
- Round-robin arbitration selects a winner; the winner drives the registered We/Waddr/Wdata outputs that feed the register file.
- A per-register Pending bitmap lets decode stall reads on in-flight writes.

Parameters:
- AW, 3, register address width.
- DW, 8, register data width.
- NREG, 1<<AW, number of registers (width of Pending).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- A_valid  in  1  requester A offers a write.
- A_ready  out  1  A offer accepted on this edge when A_valid & A_ready.
- A_addr  in  AW  A target register.
- A_data  in  DW  A write data.
- B_valid  in  1  requester B offers a write.
- B_ready  out  1  B offer accepted on this edge when B_valid & B_ready.
- B_addr  in  AW  B target register.
- B_data  in  DW  B write data.
- We  out  1  register-file write enable (registered).
- Waddr  out  AW  register-file write address (registered).
- Wdata  out  DW  register-file write data (registered).
- Pending  out  NREG  bit i = a write to register i is held or on the port.
- Idle  out  1  both holds empty and We low.

Behaviour:
- Reset (Rst_n low, asynchronous) clears:
  - hold_a.v and hold_b.v to 0; rr_ptr to 0 (A favoured).
  - We, Waddr, Wdata to 0.
  - Pending reads 0 and Idle reads 1.
  - A_ready and B_ready are forced 0 while Rst_n is low.
- Reset mid-operation discards all held and in-flight writes; no We pulse follows reset release.
- Ready rule (per side X): X_ready = ~hold_x.v | gnt_x (combinational). This gives back-to-back acceptance at one write per cycle per side when uncontested.
- Accept: on an edge with X_valid & X_ready, hold_x loads {1, addr, data}. Requester fields must be stable while valid is high and ready is low.
- Arbitration (combinational, over hold valids only):
  - Neither valid: no grant.
  - Only one valid: grant that side.
  - Both valid: grant the side selected by rr_ptr.
  - On every grant, rr_ptr is set to the side that did not win.
- Granted hold: on the next edge its valid clears (unless reloaded the same edge) and We<=1, Waddr<=addr, Wdata<=data. With no grant, We<=0 and Waddr/Wdata hold their values.
- Latency: accept at edge k -> We high in the cycle after edge k+1 -> register file updated at edge k+2 when uncontested. Each loss in arbitration adds 1 cycle.
- Throughput: one register-file write per cycle total. Under contention the losing side's ready stays low until it is granted.
- Same address on both sides: both writes are issued in grant order; the later grant is final.
- Pending[i] = (hold_a.v & hold_a.addr==i) | (hold_b.v & hold_b.addr==i) | (We & Waddr==i). It is combinational from registers only, with no input-to-output path.
- Idle = ~hold_a.v & ~hold_b.v & ~We.

Optional Feature:
- FIXED_PRIO_EN defined:
  - A always wins contention; rr_ptr is removed.
  - B is served only in cycles where hold_a is empty.
- Not defined: round-robin as specified above.

Decomposition:
- Shared package rf_pkg holds:
  - RF_AW=3, RF_DW=8, RF_NREG=8.
  - typedef rf_wr_t {logic v; logic [RF_AW-1:0] addr; logic [RF_DW-1:0] data;}.
  - Enum for arbiter side SIDE_A=0, SIDE_B=1.
- Sub-module rf_req_hold: a one-entry holding register with the valid/ready rule, instantiated once for A and once for B. The arbiter and output register stay in the top module.

Test Plan:
- Reset: assert Rst_n=0 mid-stream with both holds full -> We=0, Pending=8'h00, Idle=1, both readys 0 immediately; after release no write is issued.
- Single write: A writes addr 3, data 8'h5A at edge k -> We=1, Waddr=3, Wdata=8'h5A in cycle k+1..k+2; Pending[3]=1 from edge k until We drops.
- Contention round-robin: A and B both valid every cycle with distinct addresses, starting after reset -> grant order A,B,A,B...; each side sees ready high every other cycle.
- Same address: A writes r5=8'h11 and B writes r5=8'h22 in the same cycle, rr_ptr=A -> We pulses twice, 8'h11 then 8'h22; final r5=8'h22.
- Streaming: B alone presents 8 back-to-back writes r0..r7 with data 8'h80+i -> B_ready stays 1, We is high for 8 consecutive cycles, and the register file ends holding 8'h80..8'h87.
- FIXED_PRIO_EN: A valid continuously plus one B request -> B_ready stays 0 and B's write never issues until A deasserts, then issues next cycle.
